// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler: latches cabin/hall requests and picks the next target floor in SCAN order
module elevator_request_scheduler #(
  parameter int BUTTONS_WIDTH = 6,
  parameter int FLOOR_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic [BUTTONS_WIDTH-1:0] btn_num_in,
  input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
  input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
  input  logic [FLOOR_W-1:0] current_floor,
  input  logic door_open,
  output logic [FLOOR_W-1:0] next_floor,
  output logic req_valid,
  output logic dir,
  output logic [BUTTONS_WIDTH-1:0] pending_in,
  output logic [BUTTONS_WIDTH-1:0] pending_up,
  output logic [BUTTONS_WIDTH-1:0] pending_down
);
  typedef enum logic [1:0] {IDLE, SWEEP_UP, SWEEP_DOWN} state_t;
  localparam logic [BUTTONS_WIDTH-1:0] MASK_UP = {1'b0, {(BUTTONS_WIDTH-1){1'b1}}};
  localparam logic [BUTTONS_WIDTH-1:0] MASK_DN = {{(BUTTONS_WIDTH-1){1'b1}}, 1'b0};
  state_t state, state_nx;
  logic [BUTTONS_WIDTH-1:0] hot, all_req, up_set, dn_set, clr_in, clr_up, clr_dn, in_nx, up_nx, dn_nx;
  logic [FLOOR_W-1:0] ua, da, db, ub, tgt;
  logic above, below, here_up, here_dn, ua_ok, da_ok, db_ok, ub_ok;
  assign all_req = pending_in | pending_up | pending_down;
  assign up_set = pending_in | pending_up;
  assign dn_set = pending_in | pending_down;
  assign here_up = |(up_set & hot);
  assign here_dn = |(dn_set & hot);
  assign dir = state == SWEEP_UP;
  always_comb begin
    hot = '0;
    above = 1'b0;
    below = 1'b0;
    ua_ok = 1'b0;
    da_ok = 1'b0;
    db_ok = 1'b0;
    ub_ok = 1'b0;
    ua = '0;
    da = '0;
    db = '0;
    ub = '0;
    for (int f = 0; f < BUTTONS_WIDTH; f++) begin
      hot[f] = f == int'(current_floor);
      above |= all_req[f] && f > int'(current_floor);
      below |= all_req[f] && f < int'(current_floor);
      if (f > int'(current_floor) && up_set[f] && !ua_ok) begin
        ua_ok = 1'b1;
        ua = FLOOR_W'(f);
      end
      if (f > int'(current_floor) && pending_down[f]) begin
        da_ok = 1'b1;
        da = FLOOR_W'(f);
      end
      if (f < int'(current_floor) && dn_set[f]) begin
        db_ok = 1'b1;
        db = FLOOR_W'(f);
      end
      if (f < int'(current_floor) && pending_up[f] && !ub_ok) begin
        ub_ok = 1'b1;
        ub = FLOOR_W'(f);
      end
    end
  end
  always_comb begin
    state_nx = IDLE;
    if (state == SWEEP_UP)
      state_nx = (above || here_up) ? SWEEP_UP : below ? SWEEP_DOWN : IDLE;
    else if (state == SWEEP_DOWN)
      state_nx = (below || here_dn) ? SWEEP_DOWN : above ? SWEEP_UP : IDLE;
    else
      state_nx = above ? SWEEP_UP : below ? SWEEP_DOWN : IDLE;
  end
  always_comb begin
    clr_in = door_open ? hot : '0;
    clr_up = (door_open && state_nx != SWEEP_DOWN) ? hot : '0;
    clr_dn = (door_open && state_nx != SWEEP_UP) ? hot : '0;
    in_nx = (pending_in | btn_num_in) & ~clr_in;
    up_nx = (pending_up | btn_up_out) & ~clr_up & MASK_UP;
    dn_nx = (pending_down | btn_down_out) & ~clr_dn & MASK_DN;
    tgt = state_nx == SWEEP_UP ? (here_up ? current_floor : ua_ok ? ua : da_ok ? da : current_floor) :
          state_nx == SWEEP_DOWN ? (here_dn ? current_floor : db_ok ? db : ub_ok ? ub : current_floor) :
          current_floor;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pending_in <= '0;
      pending_up <= '0;
      pending_down <= '0;
      next_floor <= '0;
      req_valid <= 1'b0;
    end else begin
      state <= state_nx;
      pending_in <= in_nx;
      pending_up <= up_nx;
      pending_down <= dn_nx;
      next_floor <= tgt;
      req_valid <= |(in_nx | up_nx | dn_nx);
    end
  end
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb_elevator_request_scheduler: directed checks of request latching, SCAN targeting, service clears and reset
module tb_elevator_request_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] btn_num_in = '0, btn_up_out = '0, btn_down_out = '0;
  logic [2:0] current_floor = '0;
  logic door_open = 1'b0;
  logic [2:0] next_floor;
  logic req_valid, dir;
  logic [5:0] pending_in, pending_up, pending_down;
  int total = 0;
  int bad = 0;
  elevator_request_scheduler #(.BUTTONS_WIDTH(6), .FLOOR_W(3)) dut (
    .clk(clk), .reset(reset), .btn_num_in(btn_num_in), .btn_up_out(btn_up_out),
    .btn_down_out(btn_down_out), .current_floor(current_floor), .door_open(door_open),
    .next_floor(next_floor), .req_valid(req_valid), .dir(dir),
    .pending_in(pending_in), .pending_up(pending_up), .pending_down(pending_down)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    #12;
    chk("rst_in", 32'(pending_in), 0);
    chk("rst_nf", 32'(next_floor), 0);
    chk("rst_rv", 32'(req_valid), 0);
    reset = 1'b1;
    tick();
    btn_num_in = 6'b010000;
    tick();
    btn_num_in = '0;
    chk("single_lamp", 32'(pending_in), 32'b010000);
    chk("single_rv", 32'(req_valid), 1);
    tick();
    chk("single_nf", 32'(next_floor), 4);
    chk("single_dir", 32'(dir), 1);
    btn_up_out = 6'b000100;
    tick();
    btn_up_out = '0;
    tick();
    chk("pre_rst_nf", 32'(next_floor), 2);
    chk("pre_rst_up", 32'(pending_up), 32'b000100);
    #2;
    reset = 1'b0;
    #1;
    chk("async_in", 32'(pending_in), 0);
    chk("async_up", 32'(pending_up), 0);
    chk("async_nf", 32'(next_floor), 0);
    chk("async_rv", 32'(req_valid), 0);
    chk("async_dir", 32'(dir), 0);
    current_floor = 3'd3;
    reset = 1'b1;
    tick();
    chk("post_rst_nf", 32'(next_floor), 3);
    chk("post_rst_dir", 32'(dir), 0);
    chk("post_rst_rv", 32'(req_valid), 0);
    current_floor = 3'd2;
    btn_num_in = 6'b100000;
    tick();
    btn_num_in = '0;
    tick();
    chk("mid_nf5", 32'(next_floor), 5);
    chk("mid_dir", 32'(dir), 1);
    btn_up_out = 6'b001000;
    tick();
    btn_up_out = '0;
    tick();
    chk("mid_nf3", 32'(next_floor), 3);
    chk("mid_up3", 32'(pending_up), 32'b001000);
    current_floor = 3'd3;
    door_open = 1'b1;
    tick();
    door_open = 1'b0;
    chk("mid_clr_up", 32'(pending_up), 0);
    chk("mid_keep_in", 32'(pending_in), 32'b100000);
    tick();
    chk("mid_nf_next", 32'(next_floor), 5);
    current_floor = 3'd2;
    btn_down_out = 6'b001000;
    tick();
    btn_down_out = '0;
    tick();
    chk("turn_nf5", 32'(next_floor), 5);
    chk("turn_dn3", 32'(pending_down), 32'b001000);
    current_floor = 3'd5;
    door_open = 1'b1;
    tick();
    chk("turn_clr_in", 32'(pending_in), 0);
    tick();
    door_open = 1'b0;
    chk("turn_dir", 32'(dir), 0);
    chk("turn_nf3", 32'(next_floor), 3);
    chk("turn_keep_dn", 32'(pending_down), 32'b001000);
    current_floor = 3'd3;
    door_open = 1'b1;
    tick();
    door_open = 1'b0;
    chk("dn_clr", 32'(pending_down), 0);
    chk("dn_rv", 32'(req_valid), 0);
    tick();
    chk("dn_idle_nf", 32'(next_floor), 3);
    chk("dn_idle_dir", 32'(dir), 0);
    current_floor = 3'd1;
    door_open = 1'b1;
    btn_up_out = 6'b100000;
    btn_down_out = 6'b000001;
    btn_num_in = 6'b000010;
    tick();
    chk("mask_up", 32'(pending_up), 0);
    chk("mask_dn", 32'(pending_down), 0);
    chk("mask_in", 32'(pending_in), 0);
    tick();
    chk("mask_rv", 32'(req_valid), 0);
    door_open = 1'b0;
    btn_up_out = '0;
    btn_down_out = '0;
    btn_num_in = '0;
    current_floor = 3'd4;
    tick();
    chk("idle_follow", 32'(next_floor), 4);
    current_floor = 3'd2;
    btn_num_in = 6'b000010;
    btn_up_out = 6'b001000;
    btn_down_out = 6'b010000;
    tick();
    btn_num_in = '0;
    btn_up_out = '0;
    btn_down_out = '0;
    chk("sim_in", 32'(pending_in), 32'b000010);
    chk("sim_up", 32'(pending_up), 32'b001000);
    chk("sim_dn", 32'(pending_down), 32'b010000);
    tick();
    chk("sim_dir", 32'(dir), 1);
    chk("sim_nf", 32'(next_floor), 3);
    current_floor = 3'd7;
    door_open = 1'b1;
    tick();
    door_open = 1'b0;
    chk("oor_dir", 32'(dir), 0);
    chk("oor_nf", 32'(next_floor), 4);
    chk("oor_keep_in", 32'(pending_in), 32'b000010);
    chk("oor_keep_dn", 32'(pending_down), 32'b010000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Request latch and dispatcher that feeds the elevator controller its target floor. It registers cabin and hall button presses and tracks the sweep direction, using SCAN ordering to choose the next floor to serve. It outputs `next_floor` and `req_valid` for the controller's IDLE/UP/DOWN decisions. When the controller reports the car stopped with the door open at a floor, the block clears the requests that stop has served.

## Interface
- `BUTTONS_WIDTH`, default 6: number of floors, one button bit per floor (bit 0 = ground).
- `FLOOR_W`, default 3: floor index width; must satisfy 2^FLOOR_W >= BUTTONS_WIDTH.
- `clk` in 1: single clock, all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `btn_num_in` in BUTTONS_WIDTH: cabin floor buttons, level-sensitive, one bit per floor.
- `btn_up_out` in BUTTONS_WIDTH: hall "up" buttons; bit BUTTONS_WIDTH-1 is ignored.
- `btn_down_out` in BUTTONS_WIDTH: hall "down" buttons; bit 0 is ignored.
- `current_floor` in FLOOR_W: floor the car is currently at or passing.
- `door_open` in 1: car is stopped at `current_floor` with the door open (service strobe, level).
- `next_floor` out FLOOR_W: registered target floor.
- `req_valid` out 1: at least one request is pending.
- `dir` out 1: sweep direction, 1 = up, 0 = down or idle.
- `pending_in`, `pending_up`, `pending_down` out BUTTONS_WIDTH each: latched requests; these also drive the button lamps.

## Operation
- **Latching:** `pending_X <= (pending_X | btn_X) & ~clr_X & mask_X` for each of the three request sets.
  - `mask_up` clears the top-floor bit; `mask_down` clears bit 0.
- **Derived terms** (let `all = pending_in | pending_up | pending_down`, `c = current_floor`):
  - `above` = any `all[f]` set with f > c.
  - `below` = any `all[f]` set with f < c.
  - `here` = `all[c]`.
- **Service clear** (only while `door_open = 1` and c < BUTTONS_WIDTH):
  - `pending_in[c]` is always cleared.
  - If the state being entered is SWEEP_UP, clear `pending_up[c]`.
  - If it is SWEEP_DOWN, clear `pending_down[c]`.
  - If it is IDLE, clear both hall bits at c.
  - A clear wins over a simultaneous press at the same bit.
- **Direction FSM** (states IDLE, SWEEP_UP, SWEEP_DOWN):
  - IDLE: `above` -> SWEEP_UP; else `below` -> SWEEP_DOWN; else stay.
  - SWEEP_UP: stay while `above`, or while `pending_in[c] | pending_up[c]`. Otherwise go to SWEEP_DOWN if `below`, else IDLE.
  - SWEEP_DOWN: mirror image of SWEEP_UP.
  - `dir` = 1 only in SWEEP_UP.
- **Target selection** (computed from the state being entered at the same edge, then registered):
  - SWEEP_UP: c if `(pending_in | pending_up)[c]`. Else the lowest f > c with `(pending_in | pending_up)[f]`. Else the highest f > c with `pending_down[f]` (turnaround floor).
  - SWEEP_DOWN: c if `(pending_in | pending_down)[c]`. Else the highest f < c with `(pending_in | pending_down)[f]`. Else the lowest f < c with `pending_up[f]`.
  - IDLE: c.
- **`req_valid`** is registered as `|all_next`, where `all_next` is the pending set after this cycle's presses and clears.
- **Out-of-range floor:** if `current_floor >= BUTTONS_WIDTH`, no clears occur. `above`/`below` are evaluated numerically, so all requests count as below.

## Timing
- **Reset:** while `reset = 0`, all outputs and state are held at zero.
  - All `pending_*` = 0, state = IDLE, `next_floor` = 0, `req_valid` = 0, `dir` = 0.
  - Reset takes effect asynchronously, including mid-sweep; release is synchronous to the next edge.
- **Press to lamp:** a press sampled at edge k appears in `pending_*` after edge k.
- **Press to target:** `next_floor`/`dir` reflect that request after edge k+1 (2-cycle latency).
- **Service to clear:** `door_open` sampled at edge k clears the bits after edge k. `next_floor` moves to the next target after edge k+1.
- **Held buttons:** a button held during `door_open` at its own floor is never latched. If still held after `door_open` falls, it latches on the next edge.
- **Simultaneous presses:** any number of presses in one cycle are all latched; there is no arbitration loss.
- **Idle output:** with nothing pending, `next_floor` follows `current_floor` with 1-cycle latency and `req_valid` = 0.

## Test plan
- **Reset:** pending {in[4], up[2]}, SWEEP_UP; drop `reset` between edges -> all outputs 0 immediately; after release, state IDLE and `next_floor` = `current_floor`.
- **Single request:** c = 0, pulse `btn_num_in[4]` for 1 cycle -> `pending_in` = 6'b010000 after 1 edge; `next_floor` = 4, `dir` = 1, `req_valid` = 1 after 2 edges.
- **Intermediate stop:** c = 2, SWEEP_UP to in[5]; press `btn_up_out[3]` -> `next_floor` = 3. At c = 3 with `door_open` = 1 -> `pending_up[3]` clears, then `next_floor` = 5.
- **Turnaround:** c = 2 with in[5] and down[3] pending -> `next_floor` = 5 (down[3] skipped). At c = 5 with `door_open` -> state SWEEP_DOWN, `dir` = 0, `next_floor` = 3.
- **Masked and served bits:** press `btn_up_out[5]`, `btn_down_out[0]`, and `btn_num_in[c]` during `door_open` -> none of these bits ever set; `req_valid` stays 0.
- **Simultaneous presses:** press in[1], up[3], down[4] in the same cycle at c = 2, IDLE -> all three latch; state SWEEP_UP, `next_floor` = 3.
